// File: rtl/lock_pkg.sv
// Shared definitions for the digit-lock front-end and the lock FSMs.
// Contents: debounce state encoding, digit bus width, largest decimal digit.
package lock_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } lock_state_t;

endpackage

// File: rtl/sync_nff.sv
// Generic N-stage flip-flop synchroniser for asynchronous pad inputs.
// Ports: clk, rst_n (async active-low), d (raw W-bit input), q (synchronised output).
module sync_nff #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= {stg[N-2:0], d};
        end
    end

    assign q = stg[N-1];

endmodule

// File: rtl/lock_keypad_conditioner.sv
// Keypad front-end: synchronises, debounces enter, emits one pulse per press with a stable digit.
// Ports: clk, rst_n, enter_raw, digit_raw in; enter_pulse, digit_out, digit_invalid, busy out.
module lock_keypad_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DIGIT_W         = lock_pkg::DIGIT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enter_raw,
    input  logic [DIGIT_W-1:0] digit_raw,
    output logic               enter_pulse,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_invalid,
    output logic               busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CMAX = '1;

    logic               enter_s;
    logic [DIGIT_W-1:0] digit_s;

    sync_nff #(.W(1), .N(SYNC_STAGES)) u_sync_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (enter_raw),
        .q     (enter_s)
    );

    sync_nff #(.W(DIGIT_W), .N(SYNC_STAGES)) u_sync_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (digit_raw),
        .q     (digit_s)
    );

    lock_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [DIGIT_W-1:0] ref_q, ref_d;
    logic [DIGIT_W-1:0] dout_d;
    logic               pulse_d, inv_d, busy_d;

    // Saturating increment: the counter never wraps back into a valid window.
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ref_q         <= '0;
            enter_pulse   <= 1'b0;
            digit_out     <= '0;
            digit_invalid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_q         <= ref_d;
            enter_pulse   <= pulse_d;
            digit_out     <= dout_d;
            digit_invalid <= inv_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        pulse_d = 1'b0;
        dout_d  = digit_out;
        inv_d   = digit_invalid;
        unique case (state_q)
            IDLE: begin
                if (enter_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                    ref_d   = digit_s;
                end
            end
            PRESS_WAIT: begin
                if (!enter_s) begin
                    state_d = IDLE;
                end else if (digit_s != ref_q) begin
                    // Digit moved under the press: restart the window on the new code.
                    cnt_d = '0;
                    ref_d = digit_s;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                    dout_d  = ref_q;
                    inv_d   = (int'(ref_q) > MAX_DIGIT);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!enter_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A re-rise here is release bounce: back to HELD without a pulse.
                if (enter_s) begin
                    state_d = HELD;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_lock_keypad_conditioner.sv
// Self-checking bench for lock_keypad_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Directed press/bounce/digit/reset scenarios followed by random pad activity vs a window model.
module tb_lock_keypad_conditioner;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int DW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enter_raw;
    logic [DW-1:0] digit_raw;
    logic          enter_pulse;
    logic [DW-1:0] digit_out;
    logic          digit_invalid;
    logic          busy;

    lock_keypad_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .DIGIT_W         (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enter_raw     (enter_raw),
        .digit_raw     (digit_raw),
        .enter_pulse   (enter_pulse),
        .digit_out     (digit_out),
        .digit_invalid (digit_invalid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int npulse = 0;
    int pulse_edge = 0;

    // Reference model: the raw pins reach the debouncer SYNC edges late;
    // a press is accepted when the last DEB+1 delayed samples are all
    // pressed with one digit, and re-armed after DEB+1 released samples.
    logic          rq_e[$];
    logic [DW-1:0] rq_d[$];
    logic          eh[$];
    logic [DW-1:0] dh[$];
    logic          armed;
    logic          exp_pulse;
    logic [DW-1:0] exp_dig;
    logic          exp_inv;
    logic          exp_busy;

    task automatic model_reset();
        rq_e = {};
        rq_d = {};
        for (int i = 0; i < SYNC; i++) begin
            rq_e.push_back(1'b0);
            rq_d.push_back('0);
        end
        eh = {};
        dh = {};
        armed = 1'b1;
        exp_pulse = 1'b0;
        exp_dig = '0;
        exp_inv = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic [DW-1:0] d);
        logic se;
        logic [DW-1:0] sd;
        bit all1, all0, same;
        rq_e.push_back(e);
        rq_d.push_back(d);
        se = rq_e.pop_front();
        sd = rq_d.pop_front();
        eh.push_back(se);
        dh.push_back(sd);
        if (eh.size() > DEB + 1) begin
            void'(eh.pop_front());
            void'(dh.pop_front());
        end
        all1 = (eh.size() == DEB + 1);
        all0 = all1;
        same = 1'b1;
        foreach (eh[i]) begin
            if (eh[i] !== 1'b1) all1 = 1'b0;
            if (eh[i] !== 1'b0) all0 = 1'b0;
            if (dh[i] !== sd) same = 1'b0;
        end
        exp_pulse = 1'b0;
        if (armed && all1 && same) begin
            exp_pulse = 1'b1;
            armed = 1'b0;
            exp_dig = sd;
            exp_inv = (sd > 4'd9);
        end else if (!armed && all0) begin
            armed = 1'b1;
        end
        exp_busy = !armed || se;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pulse"}, 32'(enter_pulse), 32'(exp_pulse));
        check({tag, ".digit"}, 32'(digit_out), 32'(exp_dig));
        check({tag, ".inv"}, 32'(digit_invalid), 32'(exp_inv));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic step(input string tag, input logic e,
                        input logic [DW-1:0] d);
        enter_raw = e;
        digit_raw = d;
        @(posedge clk);
        model_edge(e, d);
        edges++;
        #1;
        check_outputs(tag);
        if (enter_pulse === 1'b1) begin
            npulse++;
            pulse_edge = edges;
        end
    endtask

    task automatic hold(input string tag, input logic e,
                        input logic [DW-1:0] d, input int n);
        for (int i = 0; i < n; i++) step(tag, e, d);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.pulse", 32'(enter_pulse), 32'(0));
        check("rst.digit", 32'(digit_out), 32'(0));
        check("rst.inv", 32'(digit_invalid), 32'(0));
        check("rst.busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int p0;
        int run;
        logic e;
        logic [DW-1:0] d;

        rst_n = 1'b0;
        enter_raw = 1'b0;
        digit_raw = '0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // 1: clean press of digit 5, pulse on edge SYNC+DEB+1
        hold("idle", 1'b0, 4'd5, 3);
        p0 = npulse;
        first = edges + 1;
        hold("t1", 1'b1, 4'd5, 20);
        check("t1.count", 32'(npulse - p0), 32'(1));
        check("t1.latency", 32'(pulse_edge - first + 1), 32'(SYNC + DEB + 1));
        hold("t1r", 1'b0, 4'd5, 10);

        // 2: press bounce
        p0 = npulse;
        step("t2", 1'b1, 4'd2);
        step("t2", 1'b0, 4'd2);
        step("t2", 1'b1, 4'd2);
        step("t2", 1'b0, 4'd2);
        first = edges + 1;
        hold("t2", 1'b1, 4'd2, 12);
        check("t2.count", 32'(npulse - p0), 32'(1));
        check("t2.latency", 32'(pulse_edge - first + 1), 32'(SYNC + DEB + 1));
        hold("t2r", 1'b0, 4'd2, 10);

        // 3: release bounce
        p0 = npulse;
        hold("t3", 1'b1, 4'd8, 10);
        step("t3", 1'b0, 4'd8);
        step("t3", 1'b1, 4'd8);
        hold("t3", 1'b0, 4'd8, 10);
        check("t3.count", 32'(npulse - p0), 32'(1));

        // 4: digit change inside the press window
        p0 = npulse;
        hold("t4", 1'b1, 4'd3, 2);
        hold("t4", 1'b1, 4'd7, 12);
        check("t4.count", 32'(npulse - p0), 32'(1));
        check("t4.digit", 32'(digit_out), 32'(7));
        hold("t4r", 1'b0, 4'd1, 10);
        check("t4.hold", 32'(digit_out), 32'(7));

        // 5: non-decimal code
        hold("t5", 1'b1, 4'hC, 10);
        check("t5.inv", 32'(digit_invalid), 32'(1));
        hold("t5r", 1'b0, 4'hC, 10);

        // 6: reset mid-press, enter held through release
        hold("t6", 1'b1, 4'd4, 4);
        check("t6.busy", 32'(busy), 32'(1));
        p0 = npulse;
        apply_reset();
        first = edges + 1;
        hold("t6", 1'b1, 4'd4, 12);
        check("t6.count", 32'(npulse - p0), 32'(1));
        check("t6.latency", 32'(pulse_edge - first + 1), 32'(SYNC + DEB + 1));
        hold("t6r", 1'b0, 4'd4, 10);

        // random pad activity with bounce-length and long runs mixed
        e = 1'b0;
        d = 4'd0;
        for (int k = 0; k < 300; k++) begin
            e = ~e;
            run = (($urandom & 3) == 0) ? int'($urandom_range(1, 3))
                                        : int'($urandom_range(1, 2 * DEB + 4));
            for (int j = 0; j < run; j++) begin
                if (($urandom & 7) == 0) d = DW'($urandom);
                step("rnd", e, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
